// File: rtl/mips_mem_pkg.sv
// Shared encodings and access-decode helpers for the memory-stage LSU.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // Byte enables for an access of the given size at the given word offset.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_BYTE: be = 4'b0001 << offset;
      SZ_HALF: be = offset[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Misaligned half/word, or the reserved size code.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane steering between the core and a 32-bit data bus: store replication
// and load lane extraction with sign/zero extension. Purely combinational.
module lsu_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        unsigned_ext,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [31:0] store_lanes,
  output logic [31:0] load_value
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Replicate right-justified store data across every lane it may land in.
  always_comb begin
    store_lanes = store_data;
    case (size)
      SZ_BYTE: store_lanes = {4{store_data[7:0]}};
      SZ_HALF: store_lanes = {2{store_data[15:0]}};
      default: store_lanes = store_data;
    endcase
  end

  // Pick the addressed byte/half out of the bus word.
  always_comb begin
    byte_lane = load_word[7:0];
    case (offset)
      2'd0: byte_lane = load_word[7:0];
      2'd1: byte_lane = load_word[15:8];
      2'd2: byte_lane = load_word[23:16];
      default: byte_lane = load_word[31:24];
    endcase
    half_lane = offset[1] ? load_word[31:16] : load_word[15:0];
  end

  // Extend the selected lane to 32 bits.
  always_comb begin
    load_value = load_word;
    case (size)
      SZ_BYTE: load_value = unsigned_ext ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      SZ_HALF: load_value = unsigned_ext ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: load_value = load_word;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: drives a variable-latency data bus, stalls
// the pipeline until completion, and flags misaligned accesses and timeouts.
//
//   state | meaning
//   IDLE  | no bus activity; aligned access stalls and launches a request
//   REQ   | bus_req held with stable address/data, waiting for bus_ack
//   DONE  | access finished; pipeline released, buserrM reported here
module mem_stage_lsu
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [1:0]  sizeM,
  input  logic        unsignedM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic        stallM,
  output logic [31:0] readdataM,
  output logic        misalignM,
  output logic        buserrM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

  lsu_state_t  state;
  logic [15:0] cnt;
  logic        buserr_q;
  logic [1:0]  req_size;
  logic [1:0]  req_off;
  logic        req_unsigned;
  logic        req_load;

  logic        access;
  logic        bad_access;
  logic        start;
  logic [1:0]  lane_size;
  logic [1:0]  lane_off;
  logic        lane_unsigned;
  logic [31:0] store_lanes;
  logic [31:0] load_value;

  // Decode the access presented by the pipeline this cycle.
  always_comb begin
    access     = memreadM | memwriteM;
    bad_access = misaligned(sizeM, aluoutM[1:0]);
    start      = (state == IDLE) && access && !bad_access;
  end

  // Stall and misalign depend on live inputs; forced low while in reset so
  // the pipeline is released the instant reset asserts.
  always_comb begin
    stallM    = reset && (start || (state == REQ));
    misalignM = reset && (state == IDLE) && access && bad_access;
    buserrM   = (state == DONE) && buserr_q;
  end

  // In IDLE the lane logic sees the pipeline (store replication); in REQ it
  // sees the captured qualifiers of the outstanding load.
  always_comb begin
    lane_size     = (state == IDLE) ? sizeM : req_size;
    lane_off      = (state == IDLE) ? aluoutM[1:0] : req_off;
    lane_unsigned = (state == IDLE) ? unsignedM : req_unsigned;
  end

  lsu_lane_align u_lane_align (
    .size         (lane_size),
    .offset       (lane_off),
    .unsigned_ext (lane_unsigned),
    .store_data   (writedataM),
    .load_word    (bus_rdata),
    .store_lanes  (store_lanes),
    .load_value   (load_value)
  );

  // Access sequencer: launch, wait for ack or timeout, report.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      buserr_q     <= 1'b0;
      req_size     <= SZ_BYTE;
      req_off      <= 2'b00;
      req_unsigned <= 1'b0;
      req_load     <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_be       <= '0;
      bus_wdata    <= '0;
      readdataM    <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt      <= '0;
          buserr_q <= 1'b0;
          if (start) begin
            state        <= REQ;
            bus_req      <= 1'b1;
            bus_we       <= memwriteM;
            bus_addr     <= {aluoutM[31:2], 2'b00};
            bus_be       <= byte_en(sizeM, aluoutM[1:0]);
            bus_wdata    <= store_lanes;
            req_size     <= sizeM;
            req_off      <= aluoutM[1:0];
            req_unsigned <= unsignedM;
            req_load     <= !memwriteM;
          end
        end
        REQ: begin
          // An ack on the last allowed cycle still completes normally.
          if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= DONE;
            if (req_load) begin
              readdataM <= load_value;
            end
          end else if (cnt == LAST_CNT) begin
            bus_req  <= 1'b0;
            buserr_q <= 1'b1;
            state    <= DONE;
            if (req_load) begin
              readdataM <= '0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE: begin
          state    <= IDLE;
          cnt      <= '0;
          buserr_q <= 1'b0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        memreadM, memwriteM, unsignedM;
  logic [1:0]  sizeM;
  logic [31:0] aluoutM, writedataM;
  logic        stallM, misalignM, buserrM;
  logic [31:0] readdataM;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_rd;

  typedef struct {
    logic        rd, wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr, wd;
    int          ack;
    logic [31:0] rdata;
    int          exp_stall;
    logic        exp_mis, exp_err, exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata, exp_rd;
  } vec_t;

  vec_t tbl[11];

  mem_stage_lsu #(.TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .memreadM(memreadM), .memwriteM(memwriteM), .sizeM(sizeM), .unsignedM(unsignedM),
    .aluoutM(aluoutM), .writedataM(writedataM),
    .stallM(stallM), .readdataM(readdataM), .misalignM(misalignM), .buserrM(buserrM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, wr, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, wd, input int ack, input logic [31:0] rdata,
                              input int es, input logic em, ee, input logic [3:0] ebe,
                              input logic [31:0] ea, ew, erd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wd = wd;
    v.ack = ack; v.rdata = rdata; v.exp_stall = es; v.exp_mis = em; v.exp_err = ee;
    v.exp_we = wr; v.exp_be = ebe; v.exp_addr = ea; v.exp_wdata = ew; v.exp_rd = erd;
    return v;
  endfunction

  // Reference model: expectations from the access rules using plain arithmetic.
  function automatic vec_t model(input vec_t v, input logic [31:0] prev);
    int off, nb;
    bit acc, bad, tmo;
    longint unsigned mask, val;
    off = int'(v.addr[1:0]);
    nb  = (v.sz == 2'd3) ? 4 : (1 << v.sz);
    acc = v.rd || v.wr;
    bad = (v.sz == 2'd3) || (off % nb != 0);
    v.exp_stall = 0; v.exp_mis = 0; v.exp_err = 0; v.exp_we = v.wr;
    v.exp_be = 4'd0; v.exp_addr = v.addr & ~32'd3; v.exp_wdata = 32'd0; v.exp_rd = prev;
    if (acc && bad) begin
      v.exp_mis = 1;
    end else if (acc) begin
      tmo = (v.ack < 1) || (v.ack > T);
      v.exp_stall = tmo ? 1 + T : 1 + v.ack;
      v.exp_err = tmo;
      v.exp_be = 4'(((1 << nb) - 1) << off);
      if (nb == 1) v.exp_wdata = 32'(v.wd[7:0] * 32'h0101_0101);
      else if (nb == 2) v.exp_wdata = 32'(v.wd[15:0] * 32'h0001_0001);
      else v.exp_wdata = v.wd;
      if (!v.wr) begin
        if (tmo) v.exp_rd = 32'd0;
        else begin
          mask = (64'd1 << (8 * nb)) - 1;
          val = (64'(v.rdata) >> (8 * off)) & mask;
          if (!v.uns && (((val >> (8 * nb - 1)) & 1) != 0)) val = val | ~mask;
          v.exp_rd = val[31:0];
        end
      end
    end
    return v;
  endfunction

  // Present one access, play the bus slave, then compare everything observed.
  task automatic do_vec(input vec_t v, input string tag);
    int n_stall, n_req, n_mis, n_err;
    logic [31:0] rd_out, c_addr, c_wdata;
    logic [3:0] c_be;
    logic c_we, hold_bad, done;
    n_stall = 0; n_req = 0; n_mis = 0; n_err = 0; hold_bad = 0; done = 0;
    rd_out = 32'd0; c_addr = 32'd0; c_wdata = 32'd0; c_be = 4'd0; c_we = 1'b0;
    memreadM = v.rd; memwriteM = v.wr; sizeM = v.sz; unsignedM = v.uns;
    aluoutM = v.addr; writedataM = v.wd;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      @(negedge clk);
      if (stallM) n_stall++;
      if (misalignM) n_mis++;
      if (buserrM) n_err++;
      if (bus_req) begin
        if (n_req == 0) begin
          c_addr = bus_addr; c_wdata = bus_wdata; c_be = bus_be; c_we = bus_we;
        end else if (bus_addr !== c_addr || bus_wdata !== c_wdata || bus_be !== c_be || bus_we !== c_we) begin
          hold_bad = 1;
        end
        n_req++;
        if (n_req == v.ack) begin
          bus_ack = 1'b1; bus_rdata = v.rdata;
        end else begin
          bus_rdata = $urandom;
        end
      end
      if (!stallM) begin
        rd_out = readdataM; done = 1;
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
    end
    memreadM = 0; memwriteM = 0;
    check({tag, ".completed"}, 32'(done), 32'd1);
    check({tag, ".stall_cycles"}, 32'(n_stall), 32'(v.exp_stall));
    check({tag, ".req_cycles"}, 32'(n_req), 32'((v.exp_stall > 0) ? v.exp_stall - 1 : 0));
    check({tag, ".misalign"}, 32'(n_mis), 32'(v.exp_mis));
    check({tag, ".buserr"}, 32'(n_err), 32'(v.exp_err));
    check({tag, ".readdata"}, rd_out, v.exp_rd);
    if (v.exp_stall > 0) begin
      check({tag, ".bus_be"}, 32'(c_be), 32'(v.exp_be));
      check({tag, ".bus_addr"}, c_addr, v.exp_addr);
      check({tag, ".bus_we"}, 32'(c_we), 32'(v.exp_we));
      check({tag, ".hold"}, 32'(hold_bad), 32'd0);
      if (v.exp_we) check({tag, ".bus_wdata"}, c_wdata, v.exp_wdata);
    end
  endtask

  initial begin
    vec_t r;
    reset = 0; memreadM = 0; memwriteM = 0; sizeM = 0; unsignedM = 0;
    aluoutM = 0; writedataM = 0; bus_ack = 0; bus_rdata = 0;
    model_rd = 0;

    tbl[0]  = mk(0, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 3, 32'h0,        4, 0, 0, 4'b1111, 32'h100, 32'hDEADBEEF, 32'h0);
    tbl[1]  = mk(1, 0, 2'd0, 0, 32'h203, 32'h0,        1, 32'h80FF1234, 2, 0, 0, 4'b1000, 32'h200, 32'h0,        32'hFFFFFF80);
    tbl[2]  = mk(1, 0, 2'd0, 1, 32'h203, 32'h0,        1, 32'h80FF1234, 2, 0, 0, 4'b1000, 32'h200, 32'h0,        32'h00000080);
    tbl[3]  = mk(1, 0, 2'd1, 0, 32'h102, 32'h0,        1, 32'h80017FFF, 2, 0, 0, 4'b1100, 32'h100, 32'h0,        32'hFFFF8001);
    tbl[4]  = mk(0, 1, 2'd1, 0, 32'h102, 32'h0000ABCD, 2, 32'h0,        3, 0, 0, 4'b1100, 32'h100, 32'hABCDABCD, 32'hFFFF8001);
    tbl[5]  = mk(1, 0, 2'd2, 0, 32'h101, 32'h0,        1, 32'h0,        0, 1, 0, 4'b0000, 32'h0,   32'h0,        32'hFFFF8001);
    tbl[6]  = mk(1, 0, 2'd3, 0, 32'h100, 32'h0,        1, 32'h0,        0, 1, 0, 4'b0000, 32'h0,   32'h0,        32'hFFFF8001);
    tbl[7]  = mk(1, 0, 2'd2, 0, 32'h100, 32'h0,        0, 32'h0,        5, 0, 1, 4'b1111, 32'h100, 32'h0,        32'h0);
    tbl[8]  = mk(1, 1, 2'd2, 0, 32'h104, 32'h12345678, 1, 32'hCAFEF00D, 2, 0, 0, 4'b1111, 32'h104, 32'h12345678, 32'h0);
    tbl[9]  = mk(1, 0, 2'd1, 1, 32'h100, 32'h0,        4, 32'h80017FFF, 5, 0, 0, 4'b0011, 32'h100, 32'h0,        32'h00007FFF);
    tbl[10] = mk(0, 1, 2'd0, 0, 32'h001, 32'h000000A5, 1, 32'h0,        2, 0, 0, 4'b0010, 32'h0,   32'hA5A5A5A5, 32'h00007FFF);

    // Reset state.
    #3;
    check("rst.stallM", 32'(stallM), 32'd0);
    check("rst.bus_req", 32'(bus_req), 32'd0);
    check("rst.bus_we", 32'(bus_we), 32'd0);
    check("rst.misalignM", 32'(misalignM), 32'd0);
    check("rst.buserrM", 32'(buserrM), 32'd0);
    check("rst.bus_addr", bus_addr, 32'd0);
    check("rst.bus_be", 32'(bus_be), 32'd0);
    check("rst.bus_wdata", bus_wdata, 32'd0);
    check("rst.readdataM", readdataM, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1;

    // Directed table.
    for (int i = 0; i < 11; i++) begin
      do_vec(tbl[i], $sformatf("tbl%0d", i));
    end
    model_rd = tbl[10].exp_rd;

    // Timeout, then a late ack in IDLE must be ignored.
    r = mk(1, 0, 2'd2, 0, 32'h200, 32'h0, 0, 32'h0, 5, 0, 1, 4'b1111, 32'h200, 32'h0, 32'h0);
    do_vec(r, "tmo");
    bus_ack = 1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("late_ack.bus_req", 32'(bus_req), 32'd0);
    check("late_ack.stallM", 32'(stallM), 32'd0);
    @(posedge clk); #1;
    bus_ack = 0;
    @(negedge clk);
    check("late_ack.readdataM", readdataM, 32'd0);
    check("late_ack.stallM_after", 32'(stallM), 32'd0);
    @(posedge clk); #1;

    // Reset asserted in the second REQ cycle releases bus and pipeline at once.
    memreadM = 1; sizeM = 2'd2; unsignedM = 0; aluoutM = 32'h300;
    @(negedge clk); @(posedge clk);
    @(negedge clk); @(posedge clk);
    @(negedge clk);
    check("midrst.req_before", 32'(bus_req), 32'd1);
    #2 reset = 0;
    #1;
    check("midrst.bus_req", 32'(bus_req), 32'd0);
    check("midrst.stallM", 32'(stallM), 32'd0);
    check("midrst.bus_addr", bus_addr, 32'd0);
    memreadM = 0;
    @(posedge clk); #2;
    reset = 1;
    model_rd = 32'd0;
    r = mk(1, 0, 2'd2, 0, 32'h300, 32'h0, 2, 32'h13579BDF, 3, 0, 0, 4'b1111, 32'h300, 32'h0, 32'h13579BDF);
    do_vec(r, "after_rst");
    model_rd = r.exp_rd;

    // Randomised accesses against the reference model.
    for (int i = 0; i < 60; i++) begin
      r.rd    = 1'($urandom_range(0, 1));
      r.wr    = 1'($urandom_range(0, 1));
      r.sz    = 2'($urandom_range(0, 3));
      r.uns   = 1'($urandom_range(0, 1));
      r.addr  = $urandom & 32'h0000_FFFF;
      r.wd    = $urandom;
      r.ack   = $urandom_range(0, T + 1);
      r.rdata = $urandom;
      r = model(r, model_rd);
      do_vec(r, $sformatf("rnd%0d", i));
      model_rd = r.exp_rd;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory-stage load/store unit between the pipelined datapath (aluoutM, writedataM) and a variable-latency data memory bus. It handles byte, half and word accesses, with lane steering and sign/zero extension. It stalls the pipeline until the bus acknowledges, and flags misaligned accesses and bus timeouts. On completion, readdataM feeds the MEM/WB readdata register.

Parameters:
TIMEOUT, 255, REQ-state cycles without bus_ack before a bus error is declared (1..65535).

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
memreadM  in  1  load in memory stage
memwriteM  in  1  store in memory stage
sizeM  in  2  00 byte, 01 half, 10 word, 11 illegal
unsignedM  in  1  zero-extend loads (lbu/lhu) when 1, sign-extend when 0
aluoutM  in  32  effective byte address
writedataM  in  32  store data (right-justified)
stallM  out  1  freeze F/D/E/M stages while access is in progress
readdataM  out  32  load result, extended to 32 bits
misalignM  out  1  one-cycle pulse: misaligned/illegal access dropped
buserrM  out  1  one-cycle pulse: access abandoned on timeout
bus_req  out  1  bus request
bus_we  out  1  1 write, 0 read
bus_addr  out  32  word address {aluoutM[31:2],2'b00}
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated store data
bus_ack  in  1  slave completion, one cycle
bus_rdata  in  32  read word, valid with bus_ack

Behaviour:
- Reset (reset=0, async): state IDLE. stallM, misalignM, buserrM, bus_req and bus_we are 0. bus_addr, bus_be, bus_wdata, readdataM and the timeout counter are 0. A reset mid-REQ drops bus_req immediately; the slave must tolerate the abandoned request.
- An access is active when memreadM|memwriteM. If both are high, perform the write and ignore the read.
- Misalign check: half with addr[0]=1, word with addr[1:0]!=0, or sizeM=11. On a hit in IDLE:
  - no bus request;
  - misalignM=1 combinationally that cycle;
  - stallM=0;
  - readdataM unchanged.
- FSM states IDLE, REQ, DONE.
  - IDLE with a valid aligned access: stallM=1 combinationally. At the next edge, go to REQ and register bus_req=1, bus_we, bus_addr, bus_be and bus_wdata.
  - REQ: stallM=1. Bus outputs are held stable. The counter increments each cycle.
    - bus_ack=1: register readdataM (loads only), drop bus_req, go to DONE.
    - counter reaches TIMEOUT-1 without ack: drop bus_req, set the buserr flag, go to DONE, and set readdataM=0 for loads.
  - DONE: stallM=0, so the pipeline advances past the instruction. buserrM is asserted this cycle only if a timeout occurred. Next state is IDLE unconditionally; the counter clears.
- Latency: with ack in the first REQ cycle, stallM=1 for 2 cycles and readdataM is valid in the DONE cycle (3rd cycle). Each extra wait cycle adds 1.
- bus_ack is sampled only in REQ. An ack in IDLE or DONE is ignored. bus_ack and the timeout in the same cycle: ack wins.
- Byte enables:
  - byte: 4'b0001<<addr[1:0];
  - half: addr[1]=0 gives 0011, addr[1]=1 gives 1100;
  - word: 1111.
- Store data lanes: byte replicates {4{wd[7:0]}}; half replicates {2{wd[15:0]}}; word passes through.
- Load extraction: select the addressed lane of bus_rdata, then sign-extend (unsignedM=0) or zero-extend.
- readdataM holds its last value outside DONE.

Decomposition:
- Package mips_mem_pkg:
  - size encoding constants SZ_BYTE/SZ_HALF/SZ_WORD;
  - lsu_state_t enum {IDLE,REQ,DONE};
  - function byte_en(size, addr[1:0]);
  - function misaligned(size, addr[1:0]).
- Sub-module lsu_lane_align (combinational): store replication and load extract/extend. It is reused by any future uncached I/O path.

Test Plan:
- Word store to 0x100, wd=0xDEADBEEF, ack after 3 cycles -> bus_be=1111, bus_addr=0x100, bus_wdata=0xDEADBEEF held 3 cycles; stallM high 4 cycles, then low in DONE.
- lb at 0x203, bus_rdata=0x80FF_1234, ack in first REQ cycle -> readdataM=0xFFFFFF80; repeat as lbu -> 0x00000080; stallM high exactly 2 cycles.
- lh at 0x102, bus_rdata=0x8001_7FFF -> bus_be=1100, readdataM=0xFFFF8001; sh wd=0x0000ABCD at 0x102 -> bus_wdata=0xABCDABCD, bus_be=1100.
- lw at 0x101, and sizeM=11 at 0x100 -> misalignM pulses 1 cycle, bus_req never asserts, stallM=0, readdataM unchanged.
- TIMEOUT=4, lw with no ack -> bus_req high 4 cycles then drops; DONE cycle with buserrM=1, readdataM=0; a late ack arriving in IDLE is ignored.
- Assert reset low in the 2nd REQ cycle -> bus_req and stallM go 0 immediately without a clock; after release, a new lw completes normally.
